// File: rtl/m_cond_eval.sv
// m_cond_eval: evaluates ARM-style conditions against NZCV with flag-write scoreboarding and bypass.
package m_cond_eval_pkg;
    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
    } e_cond;
endpackage

module m_cond_eval
    import m_cond_eval_pkg::*;
#(
    parameter int TAG_W       = 5,
    parameter int MAX_PENDING = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  e_cond            i_in_cond,
    input  logic             i_in_sets_flags,
    input  logic [TAG_W-1:0] i_in_tag,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_out_exec,
    output logic             o_out_sets_flags,
    output logic [TAG_W-1:0] o_out_tag,
    input  logic             i_flag_wr_valid,
    input  logic [3:0]       i_flag_wr_nzcv,
    output logic             o_err_underflow
);
    localparam int CNT_W = $clog2(MAX_PENDING + 1);

    function automatic logic f_pass(input e_cond c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            COND_EQ: f_pass = z;
            COND_NE: f_pass = !z;
            COND_CS: f_pass = cy;
            COND_CC: f_pass = !cy;
            COND_MI: f_pass = n;
            COND_PL: f_pass = !n;
            COND_VS: f_pass = v;
            COND_VC: f_pass = !v;
            COND_HI: f_pass = cy & !z;
            COND_LS: f_pass = !cy | z;
            COND_GE: f_pass = n == v;
            COND_LT: f_pass = n != v;
            COND_GT: f_pass = !z & (n == v);
            COND_LE: f_pass = z | (n != v);
            COND_AL: f_pass = 1'b1;
            default: f_pass = 1'b0;
        endcase
    endfunction

    logic [3:0]       r_nzcv;
    logic [CNT_W-1:0] r_pending;
    logic             r_err;
    logic             r_out_valid, r_out_exec, r_out_sets;
    logic [TAG_W-1:0] r_out_tag;

    logic       w_bypass, w_pass, w_resolvable, w_full, w_accept, w_inc;
    logic [3:0] w_eff;

    // The last outstanding write retiring this cycle can be consumed directly.
    assign w_bypass     = (r_pending == CNT_W'(1)) & i_flag_wr_valid;
    assign w_eff        = w_bypass ? i_flag_wr_nzcv : r_nzcv;
    assign w_pass       = f_pass(i_in_cond, w_eff);
    assign w_resolvable = (i_in_cond == COND_AL) | (i_in_cond == COND_NV) | (r_pending == '0) | w_bypass;
    assign w_full       = i_in_sets_flags & w_pass & (r_pending == CNT_W'(MAX_PENDING)) & !i_flag_wr_valid;
    assign o_in_ready   = !rst & (!r_out_valid | i_out_ready) & !i_flush & w_resolvable & !w_full;
    assign w_accept     = i_in_valid & o_in_ready;
    assign w_inc        = w_accept & i_in_sets_flags & w_pass;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_nzcv      <= '0;
            r_pending   <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_exec  <= 1'b0;
            r_out_sets  <= 1'b0;
            r_out_tag   <= '0;
        end else begin
            if (i_flag_wr_valid) r_nzcv <= i_flag_wr_nzcv;
            if (i_flag_wr_valid && r_pending == '0) r_err <= 1'b1;
            if (i_flush) r_pending <= '0;
            else if (w_inc && !i_flag_wr_valid) r_pending <= r_pending + CNT_W'(1);
            else if (!w_inc && i_flag_wr_valid && r_pending != '0) r_pending <= r_pending - CNT_W'(1);
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_exec  <= w_pass;
                r_out_sets  <= i_in_sets_flags & w_pass;
                r_out_tag   <= i_in_tag;
            end else if (i_flush || i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out_valid      = r_out_valid;
    assign o_out_exec       = r_out_exec;
    assign o_out_sets_flags = r_out_sets;
    assign o_out_tag        = r_out_tag;
    assign o_err_underflow  = r_err;
endmodule
